bit_serializer: RTL



---
 rtl/bit_serializer_pkg.sv | 9 +
 rtl/bit_serializer.sv | 80 ++++++++
 2 files changed

// File: rtl/bit_serializer_pkg.sv
// Shared types for the parallel-to-serial feeder of the sequence detector.
package bit_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/bit_serializer.sv
// Parallel word in over valid/ready, one bit per clock out on x.
// A one-word pending buffer lets consecutive words stream without gaps.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             x,
    output logic             x_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    ser_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shifter;
    logic [WIDTH-1:0] pend;
    logic             pend_valid;

    logic             last_bit;
    logic             load_now;
    logic             accept;
    logic [WIDTH-1:0] shifted;

    assign last_bit = (state == SHIFT) && (cnt == LAST);
    assign load_now = pend_valid && ((state == IDLE) || last_bit);
    // Ready depends only on registers, never on in_valid.
    assign in_ready = !pend_valid || load_now;
    assign accept   = in_valid && in_ready;

    assign shifted = LSB_FIRST ? (shifter >> 1) : (shifter << 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            shifter    <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
        end else begin
            if (accept) begin
                pend       <= in_data;
                pend_valid <= 1'b1;
            end else if (load_now) begin
                pend_valid <= 1'b0;
            end

            if (load_now) begin
                shifter <= pend;
                cnt     <= '0;
                state   <= SHIFT;
            end else if (state == SHIFT) begin
                if (cnt != LAST) begin
                    shifter <= shifted;
                    cnt     <= cnt + CNT_W'(1);
                end else begin
                    state   <= IDLE;
                    shifter <= '0;
                    cnt     <= '0;
                end
            end
        end
    end

    assign x_valid     = (state == SHIFT);
    assign x           = x_valid &&
                         (LSB_FIRST ? shifter[0] : shifter[WIDTH-1]);
    assign frame_start = x_valid && (cnt == '0);
    assign busy        = x_valid || pend_valid;

endmodule
